// File: rtl/counter_multi_pkg.sv
// Shared definitions for the multi-channel up/down counter.
// Holds the width helper used to size each channel's value bus.
package counter_multi_pkg;

  // Number of bits needed to represent val (at least one bit).
  function automatic int log2(input int val);
    int bits;
    bits = 1;
    while ((32'sd1 <<< bits) <= val) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/counter_multi_if.sv
// Control/status bundle of the multi-channel counter.
// Channel i occupies bit i of the scalar vectors and [i*WIDTH +: WIDTH] of the buses.
interface counter_multi_if
  import counter_multi_pkg::*;
#(
  parameter int NCHAN = 2,
  parameter int WIDTH = log2(255)
);
  logic [NCHAN-1:0]       clr;
  logic [NCHAN-1:0]       load;
  logic [NCHAN*WIDTH-1:0] load_value;
  logic [NCHAN-1:0]       ena;
  logic [NCHAN-1:0]       dir;
  logic [NCHAN*WIDTH-1:0] value;
  logic [NCHAN-1:0]       at_limit;
  logic [NCHAN-1:0]       tc;

  modport master (
    output clr, load, load_value, ena, dir,
    input  value, at_limit, tc
  );

  modport slave (
    input  clr, load, load_value, ena, dir,
    output value, at_limit, tc
  );
endinterface

// File: rtl/counter_multi_lane.sv
// One counter channel: clear > load > count > hold, bounded to [LOWER, UPPER].
// Arithmetic runs two bits wider than the value so offsets never overflow.
module counter_lane
  import counter_multi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LOWER = 0,
  parameter int UPPER = 255,
  parameter int STEP  = 1,
  parameter bit WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             ena,
  input  logic             dir,
  output logic [WIDTH-1:0] value,
  output logic             at_limit,
  output logic             tc
);
  localparam int AW = WIDTH + 2;
  localparam logic signed [AW-1:0] LO_C    = AW'(LOWER);
  localparam logic signed [AW-1:0] HI_C    = AW'(UPPER);
  localparam logic signed [AW-1:0] STEP_C  = AW'(STEP);
  localparam logic signed [AW-1:0] RANGE_C = AW'(UPPER - LOWER + 1);
  localparam logic signed [AW-1:0] ZERO_C  = AW'(0);

  logic signed [AW-1:0] cur_s;
  logic signed [AW-1:0] ld_s;
  logic signed [AW-1:0] off_s;
  logic signed [AW-1:0] res_s;
  logic [WIDTH-1:0]     next_value_s;
  logic                 next_tc_s;
  logic [WIDTH-1:0]     value_r;
  logic                 tc_r;

  // Next value and terminal-count flag from the prioritised controls.
  always_comb begin
    cur_s     = signed'({2'b00, value_r});
    ld_s      = signed'({2'b00, load_value});
    off_s     = ZERO_C;
    res_s     = cur_s;
    next_tc_s = 1'b0;
    if (clr) begin
      res_s = LO_C;
    end else if (load) begin
      if (ld_s < LO_C) begin
        res_s = LO_C;
      end else if (ld_s > HI_C) begin
        res_s = HI_C;
      end else begin
        res_s = ld_s;
      end
    end else if (ena) begin
      if (dir) begin
        off_s = cur_s - LO_C + STEP_C;
        if (off_s < RANGE_C) begin
          res_s = cur_s + STEP_C;
        end else begin
          next_tc_s = 1'b1;
          res_s     = WRAP ? (LO_C + off_s - RANGE_C) : HI_C;
        end
      end else begin
        off_s = cur_s - LO_C - STEP_C;
        if (off_s >= ZERO_C) begin
          res_s = cur_s - STEP_C;
        end else begin
          next_tc_s = 1'b1;
          res_s     = WRAP ? (LO_C + off_s + RANGE_C) : LO_C;
        end
      end
    end else begin
      res_s = cur_s;
    end
    next_value_s = WIDTH'(res_s);
  end

  // Value and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= WIDTH'(LOWER);
      tc_r    <= 1'b0;
    end else begin
      value_r <= next_value_s;
      tc_r    <= next_tc_s;
    end
  end

  assign value    = value_r;
  assign tc       = tc_r;
  assign at_limit = dir ? (value_r == WIDTH'(UPPER)) : (value_r == WIDTH'(LOWER));
endmodule

// File: rtl/counter_multi.sv
// NCHAN independent bounded up/down counters sharing clock and reset.
// Bit i of WRAPAROUND selects wrap (1) or saturate (0) for channel i.
module counter_multi
  import counter_multi_pkg::*;
#(
  parameter int             NCHAN      = 2,
  parameter int             LOWER      = 0,
  parameter int             UPPER      = 255,
  parameter int             STEP       = 1,
  parameter logic [NCHAN-1:0] WRAPAROUND = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  counter_multi_if.slave       bus
);
  localparam int WIDTH = log2(UPPER);

  logic [NCHAN*WIDTH-1:0] value_s;
  logic [NCHAN-1:0]       at_limit_s;
  logic [NCHAN-1:0]       tc_s;

  for (genvar g = 0; g < NCHAN; g++) begin : g_lane
    counter_lane #(
      .WIDTH (WIDTH),
      .LOWER (LOWER),
      .UPPER (UPPER),
      .STEP  (STEP),
      .WRAP  (WRAPAROUND[g])
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (bus.clr[g]),
      .load       (bus.load[g]),
      .load_value (bus.load_value[g*WIDTH +: WIDTH]),
      .ena        (bus.ena[g]),
      .dir        (bus.dir[g]),
      .value      (value_s[g*WIDTH +: WIDTH]),
      .at_limit   (at_limit_s[g]),
      .tc         (tc_s[g])
    );
  end

  assign bus.value    = value_s;
  assign bus.at_limit = at_limit_s;
  assign bus.tc       = tc_s;
endmodule

// File: tb/tb_counter_multi.sv
// Self-checking bench for counter_multi: directed vector table, async reset
// sequence, and randomized traffic against a behavioural per-channel model.
module tb_counter_multi;
  localparam int NCHAN = 2;
  localparam int L     = 2;
  localparam int U     = 9;
  localparam int S     = 3;
  localparam int R     = U - L + 1;
  localparam int W     = 4;
  localparam logic [1:0] WRAPV = 2'b01;

  logic clk;
  logic rst_n;

  counter_multi_if #(.NCHAN(NCHAN), .WIDTH(W)) bus ();

  counter_multi #(
    .NCHAN      (NCHAN),
    .LOWER      (L),
    .UPPER      (U),
    .STEP       (S),
    .WRAPAROUND (WRAPV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mv [NCHAN];
  int mt [NCHAN];

  typedef struct {
    logic [1:0] clr;
    logic [1:0] load;
    logic [3:0] lv0;
    logic [3:0] lv1;
    logic [1:0] ena;
    logic [1:0] dir;
    int         e0;
    int         e1;
    logic [1:0] etc;
    logic [1:0] eal;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dut_val(input int ch);
    return int'(bus.value[ch*W +: W]);
  endfunction

  // Behavioural next state, written from the bounded-modular-counter rules.
  task automatic model_step();
    for (int ch = 0; ch < NCHAN; ch++) begin
      int v;
      int t;
      v = mv[ch];
      t = 0;
      if (bus.clr[ch]) begin
        v = L;
      end else if (bus.load[ch]) begin
        v = int'(bus.load_value[ch*W +: W]);
        if (v < L) v = L;
        if (v > U) v = U;
      end else if (bus.ena[ch]) begin
        if (bus.dir[ch]) begin
          if (v + S <= U) v = v + S;
          else begin
            t = 1;
            v = WRAPV[ch] ? L + ((v - L + S) % R) : U;
          end
        end else begin
          if (v - S >= L) v = v - S;
          else begin
            t = 1;
            v = WRAPV[ch] ? L + ((v - L - S + R) % R) : L;
          end
        end
      end
      mv[ch] = v;
      mt[ch] = t;
    end
  endtask

  task automatic check_model(input string tag);
    for (int ch = 0; ch < NCHAN; ch++) begin
      int eal;
      eal = bus.dir[ch] ? int'(mv[ch] == U) : int'(mv[ch] == L);
      chk($sformatf("%s value ch%0d", tag, ch), dut_val(ch), mv[ch]);
      chk($sformatf("%s tc ch%0d", tag, ch), int'(bus.tc[ch]), mt[ch]);
      chk($sformatf("%s at_limit ch%0d", tag, ch), int'(bus.at_limit[ch]), eal);
    end
  endtask

  task automatic cycle(input bit use_model, input string tag);
    model_step();
    @(posedge clk);
    #1;
    if (use_model) check_model(tag);
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NCHAN; ch++) begin
      mv[ch] = L;
      mt[ch] = 0;
    end
  endtask

  initial begin
    //          clr    load   lv0    lv1    ena    dir    e0 e1 etc    eal
    vecs[0]  = '{2'b00, 2'b00, 4'd0,  4'd0,  2'b11, 2'b11, 5, 5, 2'b00, 2'b00};
    vecs[1]  = '{2'b00, 2'b00, 4'd0,  4'd0,  2'b11, 2'b11, 8, 8, 2'b00, 2'b00};
    vecs[2]  = '{2'b00, 2'b00, 4'd0,  4'd0,  2'b11, 2'b11, 3, 9, 2'b11, 2'b10};
    vecs[3]  = '{2'b00, 2'b00, 4'd0,  4'd0,  2'b11, 2'b11, 6, 9, 2'b10, 2'b10};
    vecs[4]  = '{2'b00, 2'b00, 4'd0,  4'd0,  2'b10, 2'b11, 6, 9, 2'b10, 2'b10};
    vecs[5]  = '{2'b00, 2'b00, 4'd0,  4'd0,  2'b00, 2'b11, 6, 9, 2'b00, 2'b10};
    vecs[6]  = '{2'b00, 2'b11, 4'd3,  4'd3,  2'b00, 2'b11, 3, 3, 2'b00, 2'b00};
    vecs[7]  = '{2'b00, 2'b00, 4'd0,  4'd0,  2'b11, 2'b00, 8, 2, 2'b11, 2'b10};
    vecs[8]  = '{2'b00, 2'b00, 4'd0,  4'd0,  2'b11, 2'b00, 5, 2, 2'b10, 2'b10};
    vecs[9]  = '{2'b00, 2'b11, 4'd12, 4'd0,  2'b00, 2'b00, 9, 2, 2'b00, 2'b10};
    vecs[10] = '{2'b11, 2'b11, 4'd7,  4'd7,  2'b11, 2'b11, 2, 2, 2'b00, 2'b00};
    vecs[11] = '{2'b00, 2'b11, 4'd7,  4'd4,  2'b11, 2'b11, 7, 4, 2'b00, 2'b00};
    vecs[12] = '{2'b00, 2'b00, 4'd0,  4'd0,  2'b11, 2'b10, 4, 7, 2'b00, 2'b00};
    vecs[13] = '{2'b00, 2'b00, 4'd0,  4'd0,  2'b11, 2'b01, 7, 4, 2'b00, 2'b00};
    vecs[14] = '{2'b00, 2'b00, 4'd0,  4'd0,  2'b11, 2'b01, 2, 2, 2'b11, 2'b10};
    vecs[15] = '{2'b00, 2'b00, 4'd0,  4'd0,  2'b00, 2'b11, 2, 2, 2'b00, 2'b00};

    rst_n          = 1'b0;
    bus.clr        = '0;
    bus.load       = '0;
    bus.load_value = '0;
    bus.ena        = '0;
    bus.dir        = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int ch = 0; ch < NCHAN; ch++) begin
      chk($sformatf("reset value ch%0d", ch), dut_val(ch), L);
      chk($sformatf("reset tc ch%0d", ch), int'(bus.tc[ch]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: count up/down, wrap vs saturate, load clamp, priority.
    for (int i = 0; i < 16; i++) begin
      bus.clr        = vecs[i].clr;
      bus.load       = vecs[i].load;
      bus.load_value = {vecs[i].lv1, vecs[i].lv0};
      bus.ena        = vecs[i].ena;
      bus.dir        = vecs[i].dir;
      cycle(1'b0, "table");
      chk($sformatf("vec%0d value ch0", i), dut_val(0), vecs[i].e0);
      chk($sformatf("vec%0d value ch1", i), dut_val(1), vecs[i].e1);
      chk($sformatf("vec%0d tc", i), int'(bus.tc), int'(vecs[i].etc));
      chk($sformatf("vec%0d at_limit", i), int'(bus.at_limit), int'(vecs[i].eal));
    end

    // Asynchronous reset mid-count, held across edges, then resume from LOWER.
    bus.clr  = '0;
    bus.load = '0;
    bus.ena  = 2'b11;
    bus.dir  = 2'b11;
    repeat (2) cycle(1'b1, "precount");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int ch = 0; ch < NCHAN; ch++) begin
      chk($sformatf("async rst value ch%0d", ch), dut_val(ch), L);
      chk($sformatf("async rst tc ch%0d", ch), int'(bus.tc[ch]), 0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int ch = 0; ch < NCHAN; ch++) begin
      chk($sformatf("rst held value ch%0d", ch), dut_val(ch), L);
    end
    #2;
    rst_n = 1'b1;
    cycle(1'b1, "resume");
    chk("resume ch0 first step", dut_val(0), L + S);

    // ch0 counts up steadily while ch1 sees random controls.
    for (int i = 0; i < 200; i++) begin
      bus.clr        = {1'($urandom_range(0, 7) == 0), 1'b0};
      bus.load       = {1'($urandom_range(0, 5) == 0), 1'b0};
      bus.ena        = {1'($urandom_range(0, 1)), 1'b1};
      bus.dir        = {1'($urandom_range(0, 1)), 1'b1};
      bus.load_value = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      cycle(1'b1, "indep");
    end

    // Fully random traffic on both channels.
    for (int i = 0; i < 300; i++) begin
      bus.clr        = {1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0)};
      bus.load       = {1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 6) == 0)};
      bus.ena        = 2'($urandom_range(0, 3));
      bus.dir        = 2'($urandom_range(0, 3));
      bus.load_value = 8'($urandom_range(0, 255));
      cycle(1'b1, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
